reset_sequencer: RTL and testbench

Consumes the synchronous reset produced by the board-level reset conditioner and releases a set of downstream subsystem resets one at a time. Before the first release it waits for the clock generator's lock signal to stay stable. After each release it waits for that subsystem to report ready before moving to the next. The block sits between the reset conditioner and the subsystem reset inputs. It reports completion (`all_ready`) and bring-up faults.

---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/seq_timer.sv | 24 ++
 rtl/reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_FILTER,
    S_DELAY,
    S_WAIT_READY,
    S_RUN,
    S_FAULT
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // +1 so the largest terminal value fits with headroom; counter never wraps
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter with clear and terminal-count compare, shared by all timed states.
module seq_timer #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst || clr)      cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (inc && !tc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/reset_sequencer.sv
// Releases subsystem resets one at a time after lock is stable, then monitors readiness.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES    = 3,
  parameter int LOCK_CYCLES   = 8,
  parameter int STAGE_DELAY   = 16,
  parameter int READY_TIMEOUT = 256,
  localparam int IW = idx_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic                  fault,
  output logic [IW-1:0]         fault_stage
);

  localparam int CW = cnt_width(LOCK_CYCLES, STAGE_DELAY, READY_TIMEOUT);
  localparam logic [CW-1:0] T_LOCK  = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] T_DELAY = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] T_READY = CW'(READY_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_STAGES - 1);

  seq_state_e            state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [NUM_STAGES-1:0] srst_nxt;
  logic                  ar_nxt, f_nxt;
  logic [IW-1:0]         fs_nxt, low_idx;
  logic                  t_clr, t_inc, tc;
  logic [CW-1:0]         cnt, term;

  always_comb begin
    case (state)
      S_FILTER: term = T_LOCK;
      S_DELAY:  term = T_DELAY;
      default:  term = T_READY;
    endcase
  end

  seq_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (t_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (t_inc),
    .term     (term),
    .cnt      (cnt),
    .tc       (tc)
  );

  // Lowest stage whose ready is low; only meaningful in RUN
  always_comb begin
    low_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--)
      if (!stage_ready[i]) low_idx = IW'(i);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    srst_nxt  = stage_rst;
    ar_nxt    = all_ready;
    f_nxt     = fault;
    fs_nxt    = fault_stage;
    t_clr     = 1'b0;
    t_inc     = 1'b0;
    case (state)
      S_WAIT_LOCK: begin
        idx_nxt  = '0;
        srst_nxt = '1;
        ar_nxt   = 1'b0;
        t_clr    = 1'b1;
        if (lock) state_nxt = S_FILTER;
      end
      S_FILTER: begin
        if (!lock) begin
          state_nxt = S_WAIT_LOCK;
          t_clr     = 1'b1;
        end else if (tc) begin
          state_nxt = S_DELAY;
          t_clr     = 1'b1;
        end else t_inc = 1'b1;
      end
      S_DELAY: begin
        if (!lock) begin
          state_nxt = S_WAIT_LOCK;
          srst_nxt  = '1;
          ar_nxt    = 1'b0;
          idx_nxt   = '0;
          t_clr     = 1'b1;
        end else if (tc) begin
          srst_nxt[idx] = 1'b0;
          state_nxt     = S_WAIT_READY;
          t_clr         = 1'b1;
        end else t_inc = 1'b1;
      end
      S_WAIT_READY: begin
        // ready wins over timeout on the same cycle
        if (!lock) begin
          state_nxt = S_WAIT_LOCK;
          srst_nxt  = '1;
          ar_nxt    = 1'b0;
          idx_nxt   = '0;
          t_clr     = 1'b1;
        end else if (stage_ready[idx]) begin
          t_clr = 1'b1;
          if (idx == LAST) begin
            state_nxt = S_RUN;
            ar_nxt    = 1'b1;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_DELAY;
          end
        end else if (tc) begin
          state_nxt = S_FAULT;
          srst_nxt  = '1;
          ar_nxt    = 1'b0;
          f_nxt     = 1'b1;
          fs_nxt    = idx;
          t_clr     = 1'b1;
        end else t_inc = 1'b1;
      end
      S_RUN: begin
        if (!lock) begin
          state_nxt = S_WAIT_LOCK;
          srst_nxt  = '1;
          ar_nxt    = 1'b0;
          idx_nxt   = '0;
          t_clr     = 1'b1;
        end else if (!(&stage_ready)) begin
          state_nxt = S_FAULT;
          srst_nxt  = '1;
          ar_nxt    = 1'b0;
          f_nxt     = 1'b1;
          fs_nxt    = low_idx;
        end
      end
      S_FAULT: begin
        srst_nxt = '1;
        ar_nxt   = 1'b0;
        f_nxt    = 1'b1;
        t_clr    = 1'b1;
      end
      default: begin
        state_nxt = S_WAIT_LOCK;
        srst_nxt  = '1;
        ar_nxt    = 1'b0;
        t_clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_WAIT_LOCK;
      idx         <= '0;
      stage_rst   <= '1;
      all_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      stage_rst   <= srst_nxt;
      all_ready   <= ar_nxt;
      fault       <= f_nxt;
      fault_stage <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: edge-counted stimulus with hand-computed release/fault edges (default params).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic [2:0] stage_ready = 3'b000;
  logic [2:0] stage_rst;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_stage;

  int nvec = 0;
  int nmis = 0;
  int e    = 0;

  reset_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .lock        (lock),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .all_ready   (all_ready),
    .fault       (fault),
    .fault_stage (fault_stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s at E%0d: got %0h want %0h", tag, e, got, exp);
    end
  endtask

  // inputs change #1 after edge E(e), so they are first sampled at E(e+1)
  task automatic tick();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  // last edge with rst sampled high becomes E0
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    e   = 0;
    rst = 1'b0;
  endtask

  initial begin
    // nominal bring-up + reset state
    lock = 1'b1; stage_ready = 3'b111;
    do_reset();
    chk("rst_srst", 32'(stage_rst), 7);
    chk("rst_ar",   32'(all_ready), 0);
    chk("rst_f",    32'(fault), 0);
    chk("rst_fs",   32'(fault_stage), 0);
    run_to(24); chk("nom_s0_pre",  32'(stage_rst), 7);
    run_to(25); chk("nom_s0",      32'(stage_rst), 6);
    run_to(41); chk("nom_s1_pre",  32'(stage_rst), 6);
    run_to(42); chk("nom_s1",      32'(stage_rst), 4);
    run_to(59); chk("nom_s2",      32'(stage_rst), 0);
                chk("nom_ar_pre",  32'(all_ready), 0);
    run_to(60); chk("nom_ar",      32'(all_ready), 1);

    // runtime drop of stage 2
    run_to(62); stage_ready = 3'b011;
    tick();
    chk("drop_f",    32'(fault), 1);
    chk("drop_fs",   32'(fault_stage), 2);
    chk("drop_ar",   32'(all_ready), 0);
    chk("drop_srst", 32'(stage_rst), 7);
    stage_ready = 3'b111;
    run_to(80); chk("drop_sticky", 32'(fault), 1);

    // lock loss in RUN, sequence repeats offset by 63 edges
    do_reset();
    chk("rst2_f", 32'(fault), 0);
    run_to(62); lock = 1'b0;
    tick(); lock = 1'b1;
    chk("ll_srst", 32'(stage_rst), 7);
    chk("ll_ar",   32'(all_ready), 0);
    chk("ll_f",    32'(fault), 0);
    run_to(87);  chk("ll_s0_pre", 32'(stage_rst), 7);
    run_to(88);  chk("ll_s0",     32'(stage_rst), 6);
    run_to(122); chk("ll_ar_pre", 32'(all_ready), 0);
    run_to(123); chk("ll_ar2",    32'(all_ready), 1);

    // one-cycle lock glitch during filter
    do_reset();
    run_to(5); lock = 1'b0;
    tick(); lock = 1'b1;
    run_to(30); chk("gl_s0_pre", 32'(stage_rst), 7);
    run_to(31); chk("gl_s0",     32'(stage_rst), 6);

    // ready timeout on stage 1
    stage_ready = 3'b101;
    do_reset();
    run_to(42);  chk("to_s1",    32'(stage_rst), 4);
    run_to(297); chk("to_f_pre", 32'(fault), 0);
    run_to(298); chk("to_f",     32'(fault), 1);
                 chk("to_fs",    32'(fault_stage), 1);
                 chk("to_srst",  32'(stage_rst), 7);
    stage_ready = 3'b111; lock = 1'b0;
    run_to(305); lock = 1'b1;
    run_to(320); chk("to_sticky", 32'(fault), 1);
                 chk("to_srst2",  32'(stage_rst), 7);

    // mid-sequence reset while waiting on stage 1
    stage_ready = 3'b101;
    do_reset();
    chk("rst3_fs", 32'(fault_stage), 0);
    run_to(50); chk("mid_wait", 32'(stage_rst), 4);
    rst = 1'b1;
    tick();
    chk("mid_srst", 32'(stage_rst), 7);
    chk("mid_f",    32'(fault), 0);
    e = 0; rst = 1'b0; stage_ready = 3'b111;
    run_to(25); chk("mid_s0", 32'(stage_rst), 6);
    // released stage 0 dropping before RUN is ignored
    run_to(30); stage_ready = 3'b110;
    run_to(35); stage_ready = 3'b111;
    run_to(42); chk("mid_s1",  32'(stage_rst), 4);
                chk("mid_nf",  32'(fault), 0);
    run_to(60); chk("mid_ar",  32'(all_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
